// File: rtl/fp_op_scheduler_if.sv
// Bundle between the FP op scheduler and its opcode FIFO, FP units
// and result FIFO. The scheduler is the master side.
interface fp_op_scheduler_if;
   logic        op_empty;
   logic [2:0]  op_opcode;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        op_pop;

   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        add_start;
   logic        add_sub;
   logic        mul_start;
   logic        sine_start;
   logic        sine_cos;

   logic        add_done;
   logic        mul_done;
   logic        sine_done;
   logic        add_overflow;
   logic        mul_overflow;
   logic [31:0] add_result;
   logic [31:0] mul_result;
   logic [31:0] sine_result;

   logic        res_full;
   logic        res_push;
   logic [31:0] res_data;
   logic [1:0]  res_flags;

   modport master (
      input  op_empty, op_opcode, op_a, op_b,
      output op_pop,
      output unit_a, unit_b,
      output add_start, add_sub,
      output mul_start, sine_start, sine_cos,
      input  add_done, mul_done, sine_done,
      input  add_overflow, mul_overflow,
      input  add_result, mul_result, sine_result,
      input  res_full,
      output res_push, res_data, res_flags
   );

   modport slave (
      output op_empty, op_opcode, op_a, op_b,
      input  op_pop,
      input  unit_a, unit_b,
      input  add_start, add_sub,
      input  mul_start, sine_start, sine_cos,
      output add_done, mul_done, sine_done,
      output add_overflow, mul_overflow,
      output add_result, mul_result, sine_result,
      output res_full,
      input  res_push, res_data, res_flags
   );
endinterface

// File: rtl/fp_op_scheduler.sv
// In-order single-outstanding dispatcher for the FP add/mul/sine units,
// with a watchdog that turns a hung unit into a NaN error result.
module fp_op_scheduler #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
   input  logic              clk,
   input  logic              n_rst,
   fp_op_scheduler_if.master bus,
   output logic              busy,
   output logic [15:0]       op_count
);

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, PUSH} state_t;

   state_t      state;
   logic [2:0]  opc;
   logic [15:0] wd;

   logic        in_add, in_mul, in_sin;
   logic        is_add, is_mul, is_sin, is_legal;
   logic        sel_done, sel_ovf;
   logic [31:0] sel_res;

   assign in_add = bus.op_opcode[2:1] == 2'b00;
   assign in_mul = bus.op_opcode == 3'b010;
   assign in_sin = bus.op_opcode == 3'b011
                || bus.op_opcode == 3'b100;

   assign is_add   = opc[2:1] == 2'b00;
   assign is_mul   = opc == 3'b010;
   assign is_sin   = opc == 3'b011 || opc == 3'b100;
   assign is_legal = is_add || is_mul || is_sin;

   assign bus.op_pop   = state == IDLE && !bus.op_empty;
   assign bus.res_push = state == PUSH && !bus.res_full;
   assign busy         = state != IDLE;

   // only the unit that was started may complete the op
   always_comb begin
      sel_done = 1'b0;
      sel_ovf  = 1'b0;
      sel_res  = '0;
      unique case (1'b1)
         is_add: begin
            sel_done = bus.add_done;
            sel_ovf  = bus.add_overflow;
            sel_res  = bus.add_result;
         end
         is_mul: begin
            sel_done = bus.mul_done;
            sel_ovf  = bus.mul_overflow;
            sel_res  = bus.mul_result;
         end
         is_sin: begin
            sel_done = bus.sine_done;
            sel_res  = bus.sine_result;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state          <= IDLE;
         opc            <= '0;
         wd             <= '0;
         op_count       <= '0;
         bus.unit_a     <= '0;
         bus.unit_b     <= '0;
         bus.add_sub    <= 1'b0;
         bus.sine_cos   <= 1'b0;
         bus.add_start  <= 1'b0;
         bus.mul_start  <= 1'b0;
         bus.sine_start <= 1'b0;
         bus.res_data   <= '0;
         bus.res_flags  <= '0;
      end else begin
         bus.add_start  <= 1'b0;
         bus.mul_start  <= 1'b0;
         bus.sine_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!bus.op_empty) begin
                  opc            <= bus.op_opcode;
                  bus.unit_a     <= bus.op_a;
                  bus.unit_b     <= bus.op_b;
                  bus.add_sub    <= bus.op_opcode == 3'b001;
                  bus.sine_cos   <= bus.op_opcode == 3'b100;
                  bus.add_start  <= in_add;
                  bus.mul_start  <= in_mul;
                  bus.sine_start <= in_sin;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               if (is_legal) begin
                  wd    <= '0;
                  state <= WAIT;
               end else begin
                  bus.res_data  <= NAN_VALUE;
                  bus.res_flags <= 2'b10;
                  state         <= PUSH;
               end
            end
            WAIT: begin
               // done beats a same-cycle watchdog expiry
               if (sel_done) begin
                  bus.res_data  <= sel_res;
                  bus.res_flags <= {1'b0, sel_ovf};
                  state         <= PUSH;
               end else if (wd == WD_LAST) begin
                  bus.res_data  <= NAN_VALUE;
                  bus.res_flags <= 2'b10;
                  state         <= PUSH;
               end else begin
                  wd <= wd + 16'd1;
               end
            end
            PUSH: begin
               if (!bus.res_full) begin
                  op_count <= op_count + 16'd1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_op_scheduler.sv
// Scoreboard bench for fp_op_scheduler: directed ops, random ops with
// backpressure, stray and late done strobes, and reset mid-operation.
module tb_fp_op_scheduler;

   localparam int TO = 8;
   localparam logic [31:0] NAN = 32'h7FC00000;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        busy;
   logic [15:0] op_count;

   fp_op_scheduler_if bus ();

   fp_op_scheduler #(
      .TIMEOUT_CYCLES(TO),
      .NAN_VALUE(NAN)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .bus(bus),
      .busy(busy),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        ovf;
      int          lat;
      int          hold;
   } op_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  flags;
      int          early;
      bit          exact;
   } exp_t;

   op_t  ops[$];
   exp_t sb[$];
   op_t  cur;
   exp_t mon_e;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int pop_cyc = -10;
   int cnt = 0;
   int hold_cnt = 0;
   int n_push = 0;
   bit rnd_full = 0;
   bit rnd_gap = 0;
   bit strays = 1;

   // 0 adder, 1 multiplier, 2 sine, 3 illegal
   function automatic int unit_of(logic [2:0] o);
      if (o <= 3'd1) return 0;
      if (o == 3'd2) return 1;
      if (o <= 3'd4) return 2;
      return 3;
   endfunction

   function automatic op_t mk(logic [2:0] opc, logic [31:0] a,
                              logic [31:0] b, logic [31:0] res,
                              logic ovf, int lat, int hold);
      op_t o;
      o.opc = opc; o.a = a; o.b = b; o.res = res;
      o.ovf = ovf; o.lat = lat; o.hold = hold;
      return o;
   endfunction

   // reference: what the result FIFO must receive, and no earlier than when
   function automatic exp_t model(op_t o, int p);
      exp_t e;
      int   u;
      int   w;
      u = unit_of(o.opc);
      e.exact = !rnd_full;
      if (u == 3) begin
         e.data = NAN; e.flags = 2'b10; e.early = p + 2;
      end else if (o.lat == 0 || o.lat > TO) begin
         e.data = NAN; e.flags = 2'b10; e.early = p + TO + 2;
      end else begin
         w = (o.hold > o.lat) ? o.hold : o.lat;
         e.data = o.res;
         e.flags = {1'b0, o.ovf && u != 2};
         e.early = p + w + 2;
      end
      return e;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic fire(int u, logic [31:0] r, logic ov);
      case (u)
         0: begin
            bus.add_done = 1'b1; bus.add_result = r; bus.add_overflow = ov;
         end
         1: begin
            bus.mul_done = 1'b1; bus.mul_result = r; bus.mul_overflow = ov;
         end
         2: begin
            bus.sine_done = 1'b1; bus.sine_result = r;
         end
         default: ;
      endcase
   endtask

   task automatic cycle();
      int         su;
      int         u;
      logic [2:0] sv;
      logic [2:0] ev;
      @(negedge clk);
      cyc++;
      bus.add_done = 1'b0;
      bus.mul_done = 1'b0;
      bus.sine_done = 1'b0;
      bus.add_overflow = 1'($urandom);
      bus.mul_overflow = 1'($urandom);
      bus.add_result = $urandom;
      bus.mul_result = $urandom;
      bus.sine_result = $urandom;
      if (cnt > 0) begin
         cnt--;
         if (cnt == 0) fire(unit_of(cur.opc), cur.res, cur.ovf);
      end
      if (strays && (cnt > 0 || $urandom_range(3) == 0)) begin
         su = $urandom_range(2);
         if (su != unit_of(cur.opc)) fire(su, $urandom, 1'b1);
      end
      if (hold_cnt > 0) begin
         bus.res_full = 1'b1;
         hold_cnt--;
      end else begin
         bus.res_full = rnd_full && $urandom_range(2) == 0;
      end
      if (ops.size() > 0 && !(rnd_gap && $urandom_range(3) == 0)) begin
         bus.op_empty = 1'b0;
         bus.op_opcode = ops[0].opc;
         bus.op_a = ops[0].a;
         bus.op_b = ops[0].b;
      end else begin
         bus.op_empty = 1'b1;
         bus.op_opcode = 3'($urandom);
         bus.op_a = $urandom;
         bus.op_b = $urandom;
      end
      #1;
      if (bus.op_pop) begin
         chk("pop_vs_empty", bus.op_empty, 0);
         if (!bus.op_empty) begin
            cur = ops.pop_front();
            sb.push_back(model(cur, cyc));
            pop_cyc = cyc;
         end
      end
      sv = {bus.add_start, bus.mul_start, bus.sine_start};
      if (cyc == pop_cyc + 1) begin
         u = unit_of(cur.opc);
         ev = (u == 0) ? 3'b100 : (u == 1) ? 3'b010 :
              (u == 2) ? 3'b001 : 3'b000;
         chk("start_line", sv, ev);
         if (u != 3) begin
            chk("unit_a", bus.unit_a, cur.a);
            chk("unit_b", bus.unit_b, cur.b);
            if (u == 0) chk("add_sub", bus.add_sub, cur.opc[0]);
            if (u == 2) chk("sine_cos", bus.sine_cos, cur.opc == 3'd4);
            cnt = cur.lat;
            hold_cnt = cur.hold;
         end
      end else if (sv != 3'b000) begin
         chk("stray_start", sv, 0);
      end
   endtask

   // monitor: every push is matched against the head of the scoreboard
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (n_rst) begin
            if (bus.res_full) chk("push_while_full", bus.res_push, 0);
            if (bus.res_push) begin
               chk("push_vs_pop", bus.op_pop, 0);
               if (sb.size() == 0) begin
                  chk("unexpected_push", bus.res_push, 0);
               end else begin
                  mon_e = sb.pop_front();
                  chk("res_data", bus.res_data, mon_e.data);
                  chk("res_flags", bus.res_flags, mon_e.flags);
                  chk("op_count", op_count, n_push[15:0]);
                  if (mon_e.exact) chk("push_cycle", cyc, mon_e.early);
                  else chk("push_not_early", cyc >= mon_e.early, 1);
               end
               n_push++;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got %0d cycles, want finish", cyc);
      $fatal(1, "bench timeout");
   end

   task automatic drain();
      int guard;
      guard = 0;
      while ((ops.size() > 0 || sb.size() > 0) && guard < 5000) begin
         cycle();
         guard++;
      end
      cycle();
      chk("ops_left", ops.size(), 0);
      chk("results_left", sb.size(), 0);
   endtask

   initial begin
      op_t o;
      bus.op_empty = 1'b1;
      bus.op_opcode = '0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.add_done = 1'b0;
      bus.mul_done = 1'b0;
      bus.sine_done = 1'b0;
      bus.add_overflow = 1'b0;
      bus.mul_overflow = 1'b0;
      bus.add_result = '0;
      bus.mul_result = '0;
      bus.sine_result = '0;
      bus.res_full = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_op_pop", bus.op_pop, 0);
      chk("rst_res_push", bus.res_push, 0);
      chk("rst_starts",
          {bus.add_start, bus.mul_start, bus.sine_start}, 0);
      chk("rst_unit_a", bus.unit_a, 0);
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_flags", bus.res_flags, 0);
      n_rst = 1'b1;

      ops.push_back(mk(3'd0, 32'h3F800000, 32'h40000000,
                       32'h40400000, 1'b0, 1, 0));
      ops.push_back(mk(3'd1, $urandom, $urandom,
                       32'h11111111, 1'b1, 3, 0));
      ops.push_back(mk(3'd2, $urandom, $urandom,
                       32'h22222222, 1'b0, 2, 0));
      ops.push_back(mk(3'd3, $urandom, $urandom,
                       32'h33333333, 1'b1, 4, 0));
      ops.push_back(mk(3'd4, $urandom, $urandom,
                       32'h44444444, 1'b0, 1, 0));
      ops.push_back(mk(3'd6, $urandom, $urandom,
                       32'h0, 1'b0, 0, 0));
      ops.push_back(mk(3'd2, $urandom, $urandom,
                       32'h55555555, 1'b0, 0, 0));
      ops.push_back(mk(3'd2, $urandom, $urandom,
                       32'h66666666, 1'b0, TO, 0));
      ops.push_back(mk(3'd0, $urandom, $urandom,
                       32'h77777777, 1'b1, 2, 7));
      drain();
      chk("dir_op_count", op_count, 16'(n_push));

      rnd_full = 1;
      rnd_gap = 1;
      for (int i = 0; i < 150; i++) begin
         o.opc = ($urandom_range(9) == 0) ? 3'(5 + $urandom_range(2))
                                          : 3'($urandom_range(4));
         o.a = $urandom;
         o.b = $urandom;
         o.res = $urandom;
         o.ovf = 1'($urandom);
         o.lat = $urandom_range(TO);
         o.hold = 0;
         ops.push_back(o);
      end
      drain();
      chk("rnd_op_count", op_count, 16'(n_push));

      rnd_full = 0;
      rnd_gap = 0;
      strays = 0;
      ops.push_back(mk(3'd0, $urandom, $urandom,
                       32'h12345678, 1'b0, 0, 0));
      for (int i = 0; i < 20 && ops.size() > 0; i++) cycle();
      cycle();
      chk("rst_op_issued", cyc, pop_cyc + 1);
      repeat (3) cycle();
      chk("wait_busy", busy, 1);
      n_rst = 1'b0;
      sb.delete();
      n_push = 0;
      cnt = 0;
      repeat (2) cycle();
      chk("inrst_busy", busy, 0);
      chk("inrst_op_count", op_count, 0);
      chk("inrst_res_push", bus.res_push, 0);
      n_rst = 1'b1;
      cnt = 2;
      repeat (6) cycle();
      chk("post_busy", busy, 0);
      chk("post_op_count", op_count, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
